// File: rtl/param_timer.sv
// Countdown timer that fetches its start value from the time-parameter store,
// counts it down on 1 Hz ticks and pulses expired for one clock on reaching zero.
module param_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             one_hz_enable,
  input  logic             start_timer,
  input  logic [1:0]       interval_req,
  input  logic [WIDTH-1:0] param_value,
  output logic [1:0]       interval_sel,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             expired
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    COUNT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE:  state_d = IDLE;
      FETCH: state_d = LOAD;
      LOAD: begin
        rem_d   = param_value;
        state_d = (param_value == '0) ? DONE : COUNT;
      end
      COUNT: begin
        if (one_hz_enable) begin
          rem_d = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A start request wins in every state: it aborts any load or countdown in flight.
    if (start_timer) begin
      sel_d   = interval_req;
      rem_d   = rem_q;
      state_d = FETCH;
    end
  end

  assign interval_sel = sel_q;
  assign remaining    = rem_q;
  assign busy         = (state_q == FETCH) || (state_q == LOAD) || (state_q == COUNT);
  assign expired      = (state_q == DONE);

endmodule
